// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Signed iterative (restoring) divider used by DIV in the multi-cycle MIPS
// datapath. One start pulse captures the operands, WIDTH shift/subtract
// iterations produce the magnitude quotient and remainder, and a final FIX
// cycle restores the signs (truncating division). The control FSM waits on
// done, then loads HI (remainder) and LO (quotient).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   a            signed dividend, sampled when start is accepted
//   b            signed divisor, sampled when start is accepted
//   start        request, accepted only while idle
//   quotient     signed quotient, registered, held until next completion
//   remainder    signed remainder, registered, held until next completion
//   done         one-cycle completion pulse (also on divide-by-zero)
//   div_by_zero  one-cycle pulse with done when the sampled divisor is zero
//   busy         high while an iterative division is in progress
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try subtracting the divisor. The partial remainder is
    // always below the divisor (at most 2^(WIDTH-1)), so the WIDTH+1 bit
    // difference never wraps and its top bit is a reliable sign.
    always_comb begin
        trial = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        diff  = trial - {1'b0, d_reg};
        abs_a = a[WIDTH-1] ? -a : a;
        abs_b = b[WIDTH-1] ? -b : b;
    end

    // Control and datapath state. The most-negative operand simply wraps
    // to its unsigned magnitude 2^(WIDTH-1), which gives the MIPS result
    // for the 0x80000000 / -1 overflow case with no special handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            sign_a <= a[WIDTH-1];
                            sign_b <= b[WIDTH-1];
                            q_reg  <= abs_a;
                            d_reg  <= abs_b;
                            r_reg  <= '0;
                            count  <= '0;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[WIDTH]) begin
                        r_reg <= diff;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= trial;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= (sign_a ^ sign_b) ? -q_reg : q_reg;
                    remainder <= sign_a ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    count     <= '0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
